// File: rtl/uart_echo_checker_if.sv
// UART transmit/receive handshake bundle between the echo checker (master) and the UART (slave).
interface uart_echo_checker_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_busy;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_break;

  modport master (
    output uart_tx_en,
    output uart_tx_data,
    input  uart_tx_busy,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_break
  );

  modport slave (
    input  uart_tx_en,
    input  uart_tx_data,
    output uart_tx_busy,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_break
  );
endinterface

// File: rtl/uart_echo_checker.sv
// Sends NUM_BYTES test words through a UART loopback and counts mismatched, broken or missing echoes.
// Define UART_ECHO_CHECKER_LFSR_EN for an 8-bit LFSR pattern instead of the incrementing counter.
module uart_echo_checker #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned PAYLOAD_BITS   = 8,
  parameter int unsigned NUM_BYTES      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 120_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  uart_echo_checker_if.master uart,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned IDX_W   = 16;

`ifdef UART_ECHO_CHECKER_LFSR_EN
  localparam logic [PAYLOAD_BITS-1:0] SEED = PAYLOAD_BITS'(1);
`else
  localparam logic [PAYLOAD_BITS-1:0] SEED = '0;
`endif

  // Reject parameter sets the datapath cannot honour.
  if (CLK_HZ == 0 || NUM_BYTES == 0 || NUM_BYTES > 65535 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("uart_echo_checker: illegal CLK_HZ/NUM_BYTES/TIMEOUT_CYCLES");
  end
`ifdef UART_ECHO_CHECKER_LFSR_EN
  if (PAYLOAD_BITS != 8) begin : g_bad_lfsr
    $error("uart_echo_checker: LFSR pattern needs PAYLOAD_BITS == 8");
  end
`endif

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, NEXT, DONE} state_t;

  state_t                  state;
  logic [TIMER_W-1:0]      timer;
  logic [IDX_W-1:0]        index;
  logic [PAYLOAD_BITS-1:0] pattern;

  logic [PAYLOAD_BITS-1:0] pattern_nxt_c;
  logic [15:0]             err_inc_c;
  logic                    timer_exp_c;
  logic                    idx_last_c;

`ifdef UART_ECHO_CHECKER_LFSR_EN
  assign pattern_nxt_c = {pattern[PAYLOAD_BITS-2:0],
                          pattern[7] ^ pattern[5] ^ pattern[4] ^ pattern[3]};
`else
  assign pattern_nxt_c = pattern + PAYLOAD_BITS'(1);
`endif

  assign err_inc_c   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  assign timer_exp_c = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign idx_last_c  = ((17'(index) + 17'd1) == 17'(NUM_BYTES));

  // Run sequencer; the word under test stays in pattern until NEXT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      uart.uart_tx_en   <= 1'b0;
      uart.uart_tx_data <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      err_count         <= 16'd0;
      timer             <= '0;
      index             <= '0;
      pattern           <= SEED;
    end else begin
      uart.uart_tx_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SEND;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 16'd0;
            index     <= '0;
            pattern   <= SEED;
          end
        end
        SEND: begin
          if (!uart.uart_tx_busy) begin
            uart.uart_tx_en   <= 1'b1;
            uart.uart_tx_data <= pattern;
            timer             <= '0;
            state             <= WAIT_ECHO;
          end
        end
        WAIT_ECHO: begin
          // A valid echo wins over break and timeout in the same cycle.
          if (uart.uart_rx_valid) begin
            if (uart.uart_rx_data != pattern) err_count <= err_inc_c;
            state <= NEXT;
          end else if (uart.uart_rx_break || timer_exp_c) begin
            err_count <= err_inc_c;
            state     <= NEXT;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        NEXT: begin
          pattern <= pattern_nxt_c;
          index   <= index + 16'd1;
          if (idx_last_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0);
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Scoreboard bench for uart_echo_checker: a loopback model echoes words, monitors pop expected values.
module tb_uart_echo_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_b;

  uart_echo_checker_if #(.PAYLOAD_BITS(8)) ua ();
  uart_echo_checker_if #(.PAYLOAD_BITS(8)) ub ();

  uart_echo_checker #(.PAYLOAD_BITS(8), .NUM_BYTES(4), .TIMEOUT_CYCLES(200)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .uart(ua),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a)
  );

  uart_echo_checker #(.PAYLOAD_BITS(8), .NUM_BYTES(2), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .uart(ub),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b)
  );

  // Manual drives plus loopback model drives into dut_a's UART side
  logic       man_busy, man_valid, man_break;
  logic [7:0] man_data;
  logic       mdl_valid;
  logic [7:0] mdl_data;
  bit         model_en;
  int         echo_delay;
  int         corrupt_word;

  assign ua.uart_tx_busy  = man_busy;
  assign ua.uart_rx_valid = mdl_valid | man_valid;
  assign ua.uart_rx_data  = mdl_valid ? mdl_data : man_data;
  assign ua.uart_rx_break = man_break;

  assign ub.uart_tx_busy  = 1'b0;
  assign ub.uart_rx_valid = 1'b0;
  assign ub.uart_rx_data  = 8'h00;
  assign ub.uart_rx_break = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        pass;
    logic [15:0] err;
  } status_t;

  logic [7:0] exp_tx_q[$];
  status_t    exp_st_q[$];

  // Loopback model: echo seen by the DUT echo_delay+1 cycles after the send strobe
  bit         pending;
  int         cnt;
  logic [7:0] echo_dat;
  always @(negedge clk) begin
    mdl_valid = 1'b0;
    if (!model_en) begin
      pending = 1'b0;
    end else if (ua.uart_tx_en) begin
      pending  = 1'b1;
      cnt      = echo_delay;
      echo_dat = (int'(ua.uart_tx_data) == corrupt_word) ? 8'hFF : ua.uart_tx_data;
    end else if (pending) begin
      cnt--;
      if (cnt == 0) begin
        mdl_valid = 1'b1;
        mdl_data  = echo_dat;
        pending   = 1'b0;
      end
    end
  end

  // Transmit monitor
  logic [7:0] exp_w;
  always @(negedge clk) begin
    if (!reset && ua.uart_tx_en) begin
      check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
      if (exp_tx_q.size() != 0) begin
        exp_w = exp_tx_q.pop_front();
        check("tx_data", 32'(ua.uart_tx_data), 32'(exp_w));
      end
    end
  end

  // Completion monitor
  logic    prev_done_a = 1'b0;
  status_t st;
  always @(negedge clk) begin
    if (done_a && !prev_done_a) begin
      check("status_expected", 32'(exp_st_q.size() != 0), 32'd1);
      if (exp_st_q.size() != 0) begin
        st = exp_st_q.pop_front();
        check("pass", 32'(pass_a), 32'(st.pass));
        check("err_count", 32'(err_a), 32'(st.err));
        check("busy_at_done", 32'(busy_a), 32'd0);
      end
    end
    prev_done_a = done_a;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_run(input logic ps, input logic [15:0] e, input bit with_status);
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'(i));
    if (with_status) exp_st_q.push_back('{pass: ps, err: e});
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int c = 0;
    while (!done_a && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_within_budget", 32'(done_a), 32'd1);
  endtask

  task automatic wait_tx_a(input int n, input int budget);
    int seen = 0;
    int c    = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (ua.uart_tx_en) seen++;
    end
    check("tx_within_budget", 32'(seen >= n), 32'd1);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_tx_en"},   32'(ua.uart_tx_en),   32'd0);
    check({tag, "_tx_data"}, 32'(ua.uart_tx_data), 32'd0);
    check({tag, "_busy"},    32'(busy_a),          32'd0);
    check({tag, "_done"},    32'(done_a),          32'd0);
    check({tag, "_pass"},    32'(pass_a),          32'd0);
    check({tag, "_err"},     32'(err_a),           32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int c;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    man_busy = 1'b0; man_valid = 1'b0; man_break = 1'b0; man_data = 8'h00;
    model_en = 1'b1; echo_delay = 100; corrupt_word = -1;
    tick(3);
    check_idle_a("reset");
    reset = 1'b0;
    tick(2);

    // Clean loopback, with a stray start while waiting for word 2's echo
    push_run(1'b1, 16'd0, 1'b1);
    pulse_start_a();
    check("busy_running", 32'(busy_a), 32'd1);
    check("done_cleared", 32'(done_a), 32'd0);
    wait_tx_a(2, 400);
    tick(3);
    pulse_start_a();
    wait_done_a(2000);
    tick(5);
    check("done_sticky", 32'(done_a), 32'd1);
    check("pass_sticky", 32'(pass_a), 32'd1);

    // Second echo corrupted to 0xFF, started from DONE
    corrupt_word = 1;
    push_run(1'b0, 16'd1, 1'b1);
    pulse_start_a();
    wait_done_a(2000);
    corrupt_word = -1;

    // Echo lands exactly on the timeout cycle: valid wins
    echo_delay = 199;
    push_run(1'b1, 16'd0, 1'b1);
    pulse_start_a();
    wait_done_a(3000);

    // Echo one cycle late: every word times out, late echoes ignored
    echo_delay = 200;
    push_run(1'b0, 16'd4, 1'b1);
    pulse_start_a();
    wait_done_a(3000);
    echo_delay = 100;

    // Break only on words 0,1; break with a correct echo on words 2,3
    model_en = 1'b0;
    push_run(1'b0, 16'd2, 1'b1);
    pulse_start_a();
    for (int i = 0; i < 4; i++) begin
      wait_tx_a(1, 50);
      tick(5);
      man_break = 1'b1;
      man_valid = (i >= 2);
      man_data  = 8'(i);
      tick(1);
      man_break = 1'b0;
      man_valid = 1'b0;
    end
    wait_done_a(200);
    model_en = 1'b1;

    // Transmitter busy for 20 cycles after start
    push_run(1'b1, 16'd0, 1'b1);
    @(negedge clk);
    man_busy = 1'b1;
    start_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (ua.uart_tx_en) bad = 1'b1;
    end
    man_busy = 1'b0;
    check("tx_en_held_while_busy", 32'(bad), 32'd0);
    @(negedge clk);
    check("tx_en_after_busy", 32'(ua.uart_tx_en), 32'd1);
    @(negedge clk);
    check("tx_en_single_cycle", 32'(ua.uart_tx_en), 32'd0);
    wait_done_a(2000);

    // Reset during word 3's echo wait, then a stray echo
    push_run(1'b0, 16'd0, 1'b0);
    pulse_start_a();
    wait_tx_a(3, 700);
    tick(10);
    model_en = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_idle_a("midrun_reset");
    reset = 1'b0;
    exp_tx_q.delete();
    tick(2);
    man_valid = 1'b1;
    man_data  = 8'h02;
    tick(1);
    man_valid = 1'b0;
    tick(20);
    check_idle_a("stray_rx");

    // Recovery run from IDLE
    model_en = 1'b1;
    push_run(1'b1, 16'd0, 1'b1);
    pulse_start_a();
    wait_done_a(2000);

    // No echo at all, TIMEOUT_CYCLES=50, NUM_BYTES=2
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    c = 0;
    while (!ub.uart_tx_en && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("b_first_tx", 32'(ub.uart_tx_en), 32'd1);
    check("b_first_word", 32'(ub.uart_tx_data), 32'h00);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ub.uart_tx_en && c < 200);
    check("b_tx_spacing", 32'(c), 32'd52);
    check("b_second_word", 32'(ub.uart_tx_data), 32'h01);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done_b && c < 200);
    check("b_done_latency", 32'(c), 32'd51);
    check("b_err_count", 32'(err_b), 32'd2);
    check("b_pass", 32'(pass_b), 32'd0);
    check("b_busy", 32'(busy_b), 32'd0);

    tick(5);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    check("status_queue_drained", 32'(exp_st_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
